// File: rtl/cc1200_spi_master.sv
// Single-register SPI access engine for the CC1200: CS_n assert, wait for CHIP_RDYn,
// then header / optional extended address / data bytes, MSB first, SPI mode 0.
module cc1200_spi_master #(
  parameter int CLK_DIV       = 4,
  parameter int READY_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_ext,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [7:0] rsp_status,
  output logic       rsp_timeout,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS_n,
  input  logic       MISO
);

  typedef enum logic [2:0] {IDLE, CS_WAIT, SHIFT, CS_HOLD, DONE} state_t;

  localparam int                WAIT_W    = $clog2(READY_TIMEOUT + 1);
  localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0]        GAP_FULL  = 8'(CLK_DIV);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READY_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              miso_p0, miso_p1;
  logic [7:0]        div_cnt, gap_cnt, gap_nxt;
  logic [4:0]        bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              sclk_r, ext_r, ready_r;
  logic [23:0]       tx_sr, rx_sr;
  logic              accept, half_end, last_bit;

  assign accept   = cmd_valid && ready_r;
  assign half_end = (div_cnt == DIV_LAST);
  assign last_bit = (bit_cnt == (ext_r ? 5'd23 : 5'd15));

  // MISO is asynchronous to clk
  always_ff @(posedge clk) begin
    miso_p0 <= MISO;
    miso_p1 <= miso_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CS_WAIT;
      CS_WAIT: if (!miso_p1) state_nxt = SHIFT;
               else if (wait_cnt == WAIT_LAST) state_nxt = DONE;
      SHIFT:   if (half_end && sclk_r && last_bit) state_nxt = CS_HOLD;
      CS_HOLD: if (half_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gap counter restarts in DONE and saturates at CLK_DIV while idle
  always_comb begin
    gap_nxt = gap_cnt;
    if (state == DONE) gap_nxt = 8'd0;
    else if (state == IDLE && gap_cnt != GAP_FULL) gap_nxt = gap_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r     <= 1'b0;
      gap_cnt     <= GAP_FULL;
      div_cnt     <= 8'd0;
      bit_cnt     <= 5'd0;
      wait_cnt    <= '0;
      sclk_r      <= 1'b0;
      ext_r       <= 1'b0;
      tx_sr       <= 24'd0;
      rx_sr       <= 24'd0;
      rsp_rdata   <= 8'h00;
      rsp_status  <= 8'h00;
      rsp_timeout <= 1'b0;
    end else begin
      gap_cnt <= gap_nxt;
      ready_r <= (state_nxt == IDLE) && (gap_nxt == GAP_FULL);
      case (state)
        IDLE: if (accept) begin
          ext_r    <= cmd_ext;
          wait_cnt <= '0;
          div_cnt  <= 8'd0;
          bit_cnt  <= 5'd0;
          sclk_r   <= 1'b0;
          if (cmd_ext)
            tx_sr <= {cmd_read, 7'h2F, cmd_addr, (cmd_read ? 8'h00 : cmd_wdata)};
          else
            tx_sr <= {cmd_read, 1'b0, cmd_addr[5:0], (cmd_read ? 8'h00 : cmd_wdata), 8'h00};
        end
        CS_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (state_nxt == DONE) begin
            rsp_timeout <= 1'b1;
            rsp_status  <= 8'hFF;
            rsp_rdata   <= 8'h00;
          end
        end
        SHIFT: begin
          if (half_end) begin
            div_cnt <= 8'd0;
            sclk_r  <= ~sclk_r;
            // End of the high phase: capture MISO, then advance MOSI on the fall
            if (sclk_r) begin
              rx_sr   <= {rx_sr[22:0], miso_p1};
              tx_sr   <= {tx_sr[22:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        CS_HOLD: begin
          div_cnt <= div_cnt + 8'd1;
          if (half_end) begin
            rsp_timeout <= 1'b0;
            rsp_status  <= ext_r ? rx_sr[23:16] : rx_sr[15:8];
            rsp_rdata   <= rx_sr[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = ready_r;
  assign rsp_valid = (state == DONE);
  assign SCLK      = sclk_r;
  assign MOSI      = (state == SHIFT) && tx_sr[23];
  assign CS_n      = !(state == CS_WAIT || state == SHIFT || state == CS_HOLD);

endmodule

// File: doc/cc1200_spi_master.md
# cc1200_spi_master

SPI register-access engine for the CC1200 radio on the PMOD JB header. It accepts single-register read/write commands from the processor-side register block and runs the CC1200 SPI protocol. That protocol is a CS_n assert, a wait for CHIP_RDYn (MISO low), then header, optional extended-address and data bytes, MSB first, SPI mode 0. It produces SCLK/MOSI/CS_n and consumes MISO, and these drive SCLKb/MOSIb/CS_nb/MISOb at the top level; the separate GPIO tri-state path is unaffected.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 4..255.
- READY_TIMEOUT, 4096: max clk cycles waiting for MISO low after CS_n falls.

Ports:
- clk  in  1  block clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with the inter-transaction gap elapsed.
- cmd_read  in  1  1 = register read, 0 = write.
- cmd_ext  in  1  1 = extended-space access (0x2F prefix).
- cmd_addr  in  8  standard: [5:0] used, [7:6] ignored; extended: full byte.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse at transaction end.
- rsp_rdata  out  8  MISO byte captured during the final byte.
- rsp_status  out  8  MISO byte captured during the header byte (chip status).
- rsp_timeout  out  1  qualifies rsp_valid: CHIP_RDYn never went low.
- SCLK  out  1  SPI clock, idle low.
- MOSI  out  1  SPI data out.
- CS_n  out  1  chip select, active low.
- MISO  in  1  SPI data in; asynchronous, double-flop synchronized internally.

## Operation
- Reset: CS_n=1, SCLK=0, MOSI=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0x00, rsp_status=0x00, rsp_timeout=0. State goes to IDLE, and the gap counter is preset so cmd_ready=1 on the first clk after rst falls.
- Command fields are latched on cmd_valid && cmd_ready. Inputs are ignored while cmd_ready=0.
- Byte sequence:
  - Standard access: {cmd_read, 1'b0, cmd_addr[5:0]}, then data.
  - Extended access: {cmd_read, 7'h2F}, then cmd_addr, then data.
  - The data byte is cmd_wdata for a write and 0x00 for a read.
- States:
  - IDLE → CS_WAIT on accept.
  - CS_WAIT: CS_n=0. Goes to SHIFT on the first clk where synchronized MISO=0. Goes to DONE with timeout after READY_TIMEOUT cycles in CS_WAIT.
  - SHIFT: runs 16 (standard) or 24 (extended) SCLK periods, then goes to CS_HOLD.
  - CS_HOLD: CLK_DIV cycles, SCLK=0, CS_n=0, then goes to DONE.
  - DONE: CS_n=1 and rsp_valid=1 for one cycle, then goes to IDLE.
- IDLE gap: CS_n stays high for at least CLK_DIV cycles after DONE before cmd_ready rises.
- Timeout response: rsp_timeout=1, rsp_status=0xFF, rsp_rdata=0x00. No SCLK edges are ever produced.
- rsp_rdata, rsp_status and rsp_timeout hold their values until the next DONE.
- A write still updates rsp_rdata with whatever MISO returned.

## Timing
- Accept at edge N gives CS_n=0 from N+1. A MISO fall is seen by the FSM 2–3 clks later through the synchronizer.
- SHIFT entry: MOSI = header bit7 in the same cycle, SCLK low.
- SCLK toggles every CLK_DIV clks, giving a period of 2*CLK_DIV.
- Rising SCLK: the slave samples MOSI.
- Last clk of each high phase: synchronized MISO is shifted into the capture register. CLK_DIV≥4 guarantees that synchronizer delay is less than the half-period.
- Falling SCLK: MOSI advances to the next bit. Bytes are contiguous with no gap between them.
- SHIFT duration is exactly bits*2*CLK_DIV clks.
- Total time from accept to rsp_valid is wait + bits*2*CLK_DIV + CLK_DIV + 1 clks.
- rst asserted in any state: all outputs take their reset values on the next edge (CS_n=1, SCLK=0 immediately). No rsp_valid is issued for the aborted transaction.
- If cmd_valid is held across DONE, the next command is accepted only when cmd_ready rises after the gap.

## Test plan
- Standard write, addr 0x01, data 0x5A, CLK_DIV=4, with a slave model pulling MISO low after 10 clks and returning status 0x0F.
  Required: MOSI 0x01,0x5A; 16 SCLK rising edges; SCLK period 8 clks; rsp_status=0x0F; single rsp_valid pulse; CS_n high CLK_DIV clks after the last falling SCLK.
- Extended read, addr 0x8F, with the slave returning 0x0F,0x00,0x3C.
  Required: MOSI 0xAF,0x8F,0x00; 24 SCLK edges; rsp_rdata=0x3C; rsp_timeout=0.
- MISO held high, READY_TIMEOUT=64.
  Required: CS_n low for 64 clks then high; rsp_valid with rsp_timeout=1, rsp_status=0xFF, rsp_rdata=0x00; SCLK never toggles.
- rst pulsed mid-SHIFT, during the 9th bit.
  Required: next edge gives CS_n=1, SCLK=0, MOSI=0, rsp_valid never asserted; cmd_ready=1 one clk after rst falls.
- cmd_valid held high with cmd fields changing mid-transfer, back-to-back.
  Required: the first transaction's bytes are unaffected; the second accept occurs no earlier than CLK_DIV clks after the first DONE; the CS_n high gap is ≥ CLK_DIV.
- Standard access with cmd_addr=0xC5.
  Required: header=0x05 (write) or 0x85 (read), i.e. bits [7:6] of cmd_addr ignored.
